// File: rtl/hdmi.sv
// HDMI/DVI video transmitter core: raster counters, sync generation,
// HDMI video preamble / guard-band framing and per-channel TMDS 8b/10b
// encoding. Output symbols lag the cx/cy position by two clock cycles.

// One TMDS lane: transition-minimised 8b/10b encoder with running disparity.
module hdmi_tmds_chan #(
  parameter logic [9:0] GUARD_SYM = 10'b1011001100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       video,
  input  logic       guard,
  input  logic [1:0] ctl,
  input  logic [7:0] d,
  output logic [9:0] sym
);
  logic [3:0]        n1d, n1q;
  logic              use_xnor;
  logic [8:0]        qm;
  logic signed [5:0] cnt, cnt_n, bal, two_q8, two_nq8;
  logic [9:0]        enc_sym, ctl_sym;

  // Stage A: minimise transitions (XOR or XNOR chain)
  always_comb begin
    n1d = '0;
    for (int i = 0; i < 8; i++) n1d = n1d + {3'b000, d[i]};
    use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !d[0]);
    qm = '0;
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    qm[8] = ~use_xnor;
  end

  // Stage B: DC balance against the running disparity, pick output polarity
  always_comb begin
    n1q = '0;
    for (int i = 0; i < 8; i++) n1q = n1q + {3'b000, qm[i]};
    bal     = $signed({1'b0, n1q, 1'b0}) - 6'sd8;   // ones minus zeros
    two_q8  = qm[8] ? 6'sd2 : 6'sd0;
    two_nq8 = qm[8] ? 6'sd0 : 6'sd2;
    enc_sym = {1'b0, qm[8], qm[7:0]};
    cnt_n   = cnt;
    if ((cnt == 6'sd0) || (bal == 6'sd0)) begin
      enc_sym = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      cnt_n   = qm[8] ? (cnt + bal) : (cnt - bal);
    end else if (((cnt > 6'sd0) && (bal > 6'sd0)) || ((cnt < 6'sd0) && (bal < 6'sd0))) begin
      enc_sym = {1'b1, qm[8], ~qm[7:0]};
      cnt_n   = cnt + two_q8 - bal;
    end else begin
      enc_sym = {1'b0, qm[8], qm[7:0]};
      cnt_n   = cnt - two_nq8 + bal;
    end
  end

  // Control period symbol table
  always_comb begin
    case (ctl)
      2'b00:   ctl_sym = 10'b1101010100;
      2'b01:   ctl_sym = 10'b0010101011;
      2'b10:   ctl_sym = 10'b0101010100;
      default: ctl_sym = 10'b1010101011;
    endcase
  end

  // Output register; disparity restarts at zero outside the video period
  always_ff @(posedge clk) begin
    if (reset) begin
      sym <= 10'b1101010100;
      cnt <= '0;
    end else if (video) begin
      sym <= enc_sym;
      cnt <= cnt_n;
    end else begin
      sym <= guard ? GUARD_SYM : ctl_sym;
      cnt <= '0;
    end
  end
endmodule

module hdmi #(
  parameter int  VIDEO_ID_CODE      = 1,
  parameter bit  DVI_OUTPUT         = 1'b0,
  parameter real VIDEO_REFRESH_RATE = 59.94,
  parameter int  IT_CONTENT         = 1,
  parameter int  AUDIO_RATE         = 44100,
  parameter int  AUDIO_BIT_WIDTH    = 16,
  parameter int  START_X            = 0,
  parameter int  START_Y            = 0
) (
  input  logic                            clk_pixel_x5,
  input  logic                            clk_pixel,
  input  logic                            clk_audio,
  input  logic                            reset,
  input  logic [23:0]                     rgb,
  input  logic [1:0][AUDIO_BIT_WIDTH-1:0] audio_sample_word,
  output logic [2:0][9:0]                 tmds,
  output logic [9:0]                      tmds_clock,
  output logic [10:0]                     cx,
  output logic [9:0]                      cy,
  output logic [10:0]                     frame_width,
  output logic [9:0]                      frame_height
);
  localparam bit V720 = (VIDEO_ID_CODE == 4);
  localparam int FW   = V720 ? 1650 : 800;
  localparam int FH   = V720 ? 750  : 525;
  localparam int AW   = V720 ? 1280 : 640;
  localparam int AH   = V720 ? 720  : 480;
  localparam int HFP  = V720 ? 110  : 16;
  localparam int HSW  = V720 ? 40   : 96;
  localparam int VFP  = V720 ? 5    : 10;
  localparam int VSW  = V720 ? 5    : 2;
  localparam bit SYNC_POS = V720;

  // Audio, serial clock and metadata parameters are carried for interface
  // compatibility only; fold them here so they are visibly consumed.
  localparam int unused_params = IT_CONTENT + AUDIO_RATE + $rtoi(VIDEO_REFRESH_RATE);
  logic unused_inputs;
  assign unused_inputs = ^{clk_pixel_x5, clk_audio, audio_sample_word};

  assign frame_width  = 11'(FW);
  assign frame_height = 10'(FH);
  assign tmds_clock   = 10'b0000011111;

  // Raster position counters
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      cx <= 11'(START_X);
      cy <= 10'(START_Y);
    end else if (cx == 11'(FW - 1)) begin
      cx <= '0;
      cy <= (cy == 10'(FH - 1)) ? '0 : cy + 10'd1;
    end else begin
      cx <= cx + 11'd1;
    end
  end

  logic video_s0, h_win, v_win, hsync_s0, vsync_s0, next_act, pre_s0, guard_s0;

  // Region decode for the current position
  always_comb begin
    video_s0 = (cx < 11'(AW)) && (cy < 10'(AH));
    h_win    = (cx >= 11'(AW + HFP)) && (cx < 11'(AW + HFP + HSW));
    v_win    = (cy >= 10'(AH + VFP)) && (cy < 10'(AH + VFP + VSW));
    hsync_s0 = SYNC_POS ? h_win : ~h_win;
    vsync_s0 = SYNC_POS ? v_win : ~v_win;
    // the line after this one carries pixels (last line wraps to line 0)
    next_act = (cy == 10'(FH - 1)) || (cy < 10'(AH - 1));
    pre_s0   = !DVI_OUTPUT && next_act && (cx >= 11'(FW - 10)) && (cx <= 11'(FW - 3));
    guard_s0 = !DVI_OUTPUT && next_act && (cx >= 11'(FW - 2));
  end

  logic            s1_video, s1_guard;
  logic [2:0][1:0] s1_ctl;
  logic [23:0]     s1_rgb;

  // First pipeline stage: capture pixel and framing together
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      s1_video <= 1'b0;
      s1_guard <= 1'b0;
      s1_ctl   <= '0;
      s1_rgb   <= '0;
    end else begin
      s1_video  <= video_s0;
      s1_guard  <= guard_s0;
      s1_ctl[0] <= {vsync_s0, hsync_s0};
      s1_ctl[1] <= {1'b0, pre_s0};
      s1_ctl[2] <= 2'b00;
      s1_rgb    <= rgb;
    end
  end

  // Second pipeline stage: one encoder per lane (B, G, R)
  for (genvar g = 0; g < 3; g++) begin : g_chan
    hdmi_tmds_chan #(
      .GUARD_SYM((g == 1) ? 10'b0100110011 : 10'b1011001100)
    ) u_chan (
      .clk   (clk_pixel),
      .reset (reset),
      .video (s1_video),
      .guard (s1_guard),
      .ctl   (s1_ctl[g]),
      .d     (s1_rgb[g*8 +: 8]),
      .sym   (tmds[g])
    );
  end
endmodule

// File: tb/tb_hdmi.sv
// Bench for hdmi: three instances (720p HDMI, 720p DVI, 480p HDMI) run in
// parallel from late-frame start positions against a behavioural model.
module tb_hdmi;
  localparam int N = 3;
  localparam logic [9:0] C00 = 10'b1101010100, C01 = 10'b0010101011;
  localparam logic [9:0] C10 = 10'b0101010100, C11 = 10'b1010101011;
  localparam logic [9:0] G02 = 10'b1011001100, G1 = 10'b0100110011;

  typedef struct {
    logic [2:0][9:0] sym;
    bit              video;
    logic [23:0]     rgb;
  } exp_t;

  int vic_a [N] = '{4, 4, 1};
  int dvi_a [N] = '{0, 1, 0};
  int sx_a  [N] = '{0, 0, 5};
  int sy_a  [N] = '{718, 718, 478};

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [23:0] rgb = '0;
  logic [1:0][15:0] aud = '0;
  logic [2:0][9:0] tm [N];
  logic [9:0]  tclk [N];
  logic [10:0] cx [N], fw [N];
  logic [9:0]  cy [N], fh [N];

  int n_chk = 0, n_fail = 0;
  int px [N], py [N];
  int dcnt [N][3];
  exp_t dly [N][2];
  int cnt_pre [2], cnt_g [2];
  int c11, c01, c10, bal;

  always #5 clk = ~clk;

  hdmi #(.VIDEO_ID_CODE(4), .DVI_OUTPUT(0), .START_X(0), .START_Y(718)) u0 (
    .clk_pixel_x5(clk), .clk_pixel(clk), .clk_audio(clk), .reset(reset), .rgb(rgb),
    .audio_sample_word(aud), .tmds(tm[0]), .tmds_clock(tclk[0]), .cx(cx[0]), .cy(cy[0]),
    .frame_width(fw[0]), .frame_height(fh[0]));
  hdmi #(.VIDEO_ID_CODE(4), .DVI_OUTPUT(1), .START_X(0), .START_Y(718)) u1 (
    .clk_pixel_x5(clk), .clk_pixel(clk), .clk_audio(clk), .reset(reset), .rgb(rgb),
    .audio_sample_word(aud), .tmds(tm[1]), .tmds_clock(tclk[1]), .cx(cx[1]), .cy(cy[1]),
    .frame_width(fw[1]), .frame_height(fh[1]));
  hdmi #(.VIDEO_ID_CODE(1), .DVI_OUTPUT(0), .START_X(5), .START_Y(478)) u2 (
    .clk_pixel_x5(clk), .clk_pixel(clk), .clk_audio(clk), .reset(reset), .rgb(rgb),
    .audio_sample_word(aud), .tmds(tm[2]), .tmds_clock(tclk[2]), .cx(cx[2]), .cy(cy[2]),
    .frame_width(fw[2]), .frame_height(fh[2]));

  function automatic logic [9:0] ctl_sym(input logic [1:0] c);
    case (c)
      2'b00:   return C00;
      2'b01:   return C01;
      2'b10:   return C10;
      default: return C11;
    endcase
  endfunction

  // DVI 8b/10b reference encoder in plain integer arithmetic
  function automatic logic [9:0] tmds_enc(input logic [7:0] d, input int cin, output int cout);
    int n1, ones, zeros;
    bit xn;
    logic [8:0] qm;
    logic [9:0] s;
    n1 = $countones(d);
    xn = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
    qm[0] = d[0];
    for (int b = 1; b < 8; b++) qm[b] = xn ? ~(qm[b-1] ^ d[b]) : (qm[b-1] ^ d[b]);
    qm[8] = !xn;
    ones = $countones(qm[7:0]);
    zeros = 8 - ones;
    if (cin == 0 || ones == zeros) begin
      s = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      cout = cin + (qm[8] ? ones - zeros : zeros - ones);
    end else if ((cin > 0 && ones > zeros) || (cin < 0 && zeros > ones)) begin
      s = {1'b1, qm[8], ~qm[7:0]};
      cout = cin + (qm[8] ? 2 : 0) + zeros - ones;
    end else begin
      s = {1'b0, qm[8], qm[7:0]};
      cout = cin - (qm[8] ? 0 : 2) + ones - zeros;
    end
    return s;
  endfunction

  function automatic logic [7:0] tmds_dec(input logic [9:0] s);
    logic [7:0] d, q;
    d = s[9] ? ~s[7:0] : s[7:0];
    q[0] = d[0];
    for (int b = 1; b < 8; b++) q[b] = s[8] ? (d[b] ^ d[b-1]) : ~(d[b] ^ d[b-1]);
    return q;
  endfunction

  // Expected symbols for instance i at its current position, then advance it
  task automatic model_step(input int i, input logic [23:0] c, output exp_t e);
    int fwv, fhv, aw, ah, hf, hs, vf, vs, co;
    bit pos, hact, vact, h, v, nxt, pre, grd;
    if (vic_a[i] == 4) begin
      fwv = 1650; fhv = 750; aw = 1280; ah = 720; hf = 110; hs = 40; vf = 5; vs = 5; pos = 1;
    end else begin
      fwv = 800; fhv = 525; aw = 640; ah = 480; hf = 16; hs = 96; vf = 10; vs = 2; pos = 0;
    end
    e.rgb = c;
    e.video = (px[i] < aw) && (py[i] < ah);
    hact = (px[i] >= aw + hf) && (px[i] < aw + hf + hs);
    vact = (py[i] >= ah + vf) && (py[i] < ah + vf + vs);
    h = pos ? hact : !hact;
    v = pos ? vact : !vact;
    nxt = (py[i] == fhv - 1) || (py[i] + 1 < ah);
    pre = (dvi_a[i] == 0) && nxt && (px[i] >= fwv - 10) && (px[i] <= fwv - 3);
    grd = (dvi_a[i] == 0) && nxt && (px[i] >= fwv - 2);
    if (e.video) begin
      for (int ch = 0; ch < 3; ch++) begin
        e.sym[ch] = tmds_enc(c[ch*8 +: 8], dcnt[i][ch], co);
        dcnt[i][ch] = co;
      end
    end else begin
      for (int ch = 0; ch < 3; ch++) dcnt[i][ch] = 0;
      if (grd) e.sym = {G02, G1, G02};
      else begin
        e.sym[0] = ctl_sym({v, h});
        e.sym[1] = ctl_sym({1'b0, pre});
        e.sym[2] = C00;
      end
    end
    px[i]++;
    if (px[i] == fwv) begin
      px[i] = 0;
      py[i]++;
      if (py[i] == fhv) py[i] = 0;
    end
  endtask

  task automatic model_reset();
    exp_t r;
    r.sym = {C00, C00, C00};
    r.video = 0;
    r.rgb = '0;
    for (int i = 0; i < N; i++) begin
      px[i] = sx_a[i];
      py[i] = sy_a[i];
      for (int ch = 0; ch < 3; ch++) dcnt[i][ch] = 0;
      dly[i][0] = r;
      dly[i][1] = r;
    end
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 2; i++) begin cnt_pre[i] = 0; cnt_g[i] = 0; end
    c11 = 0; c01 = 0; c10 = 0;
  endtask

  // Runs n cycles starting at a negedge: compare, drive, predict, advance
  task automatic run_cycles(input int n, input bit black);
    exp_t ent, e;
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < N; i++) begin
        ent = dly[i][1];
        n_chk++;
        if (cx[i] !== 11'(px[i]) || cy[i] !== 10'(py[i])) begin
          n_fail++;
          $display("FAIL position inst%0d: got cx=%0d cy=%0d want cx=%0d cy=%0d", i, cx[i], cy[i], px[i], py[i]);
        end
        for (int ch = 0; ch < 3; ch++) begin
          n_chk++;
          if (tm[i][ch] !== ent.sym[ch]) begin
            n_fail++;
            $display("FAIL tmds inst%0d ch%0d at (%0d,%0d): got %b want %b", i, ch, px[i], py[i], tm[i][ch], ent.sym[ch]);
          end
        end
        if (i == 0 && ent.video) begin
          n_chk++;
          if ({tmds_dec(tm[0][2]), tmds_dec(tm[0][1]), tmds_dec(tm[0][0])} !== ent.rgb) begin
            n_fail++;
            $display("FAIL decode inst0: got %h want %h", {tmds_dec(tm[0][2]), tmds_dec(tm[0][1]), tmds_dec(tm[0][0])}, ent.rgb);
          end
        end
        if (i == 0 && black && ent.video && ent.rgb == 24'h0) begin
          for (int ch = 0; ch < 3; ch++) begin
            n_chk++;
            if (tm[0][ch] !== 10'b0100000000 && tm[0][ch] !== 10'b1111111111) begin
              n_fail++;
              $display("FAIL black_symbol ch%0d: got %b want 0100000000 or 1111111111", ch, tm[0][ch]);
            end
          end
          bal += 2 * $countones(tm[0][0]) - 10;
          n_chk++;
          if (bal > 10 || bal < -10) begin
            n_fail++;
            $display("FAIL black_disparity: got %0d want within +/-10", bal);
          end
        end else if (i == 0) bal = 0;
        if (i < 2) begin
          if (tm[i][1] === C01) cnt_pre[i]++;
          if (!ent.video && tm[i][1] === G1) cnt_g[i]++;
        end
        if (i == 0) begin
          if (tm[0][0] === C11) c11++;
          if (tm[0][0] === C01) c01++;
          if (tm[0][0] === C10) c10++;
        end
      end
      rgb = black ? 24'h0 : 24'($urandom);
      for (int i = 0; i < N; i++) begin
        model_step(i, rgb, e);
        dly[i][1] = dly[i][0];
        dly[i][0] = e;
      end
      @(negedge clk);
    end
  endtask

  task automatic expect_count(input string name, input int got, input int want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rgb = 24'($urandom);
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      n_chk++;
      if (cx[i] !== 11'(sx_a[i]) || cy[i] !== 10'(sy_a[i])) begin
        n_fail++;
        $display("FAIL reset_pos inst%0d: got %0d,%0d want %0d,%0d", i, cx[i], cy[i], sx_a[i], sy_a[i]);
      end
      n_chk++;
      if (tm[i] !== {C00, C00, C00}) begin
        n_fail++;
        $display("FAIL reset_tmds inst%0d: got %h want all %b", i, tm[i], C00);
      end
      n_chk++;
      if (fw[i] !== ((vic_a[i] == 4) ? 11'd1650 : 11'd800) || fh[i] !== ((vic_a[i] == 4) ? 10'd750 : 10'd525)) begin
        n_fail++;
        $display("FAIL frame_size inst%0d: got %0dx%0d", i, fw[i], fh[i]);
      end
      n_chk++;
      if (tclk[i] !== 10'b0000011111) begin
        n_fail++;
        $display("FAIL tmds_clock inst%0d: got %b want 0000011111", i, tclk[i]);
      end
    end
    reset = 1'b0;
    model_reset();
  endtask

  // lines 718 (with preamble/guard) and 719 (next line blank: none)
  task automatic test_active_lines();
    clear_counts();
    run_cycles(2 * 1650, 1'b0);
    expect_count("preamble_718_719_hdmi", cnt_pre[0], 8);
    expect_count("preamble_718_719_dvi", cnt_pre[1], 0);
    expect_count("guard_718_hdmi", cnt_g[0], 2);
    expect_count("guard_718_dvi", cnt_g[1], 0);
  endtask

  // lines 720..749: sync windows, no framing until the last line
  task automatic test_sync_blanking();
    clear_counts();
    run_cycles(30 * 1650, 1'b0);
    expect_count("ch0_vsync_hsync", c11, 200);
    expect_count("ch0_hsync_only", c01, 1000);
    expect_count("ch0_vsync_only", c10, 8050);
    expect_count("preamble_749_hdmi", cnt_pre[0], 8);
    expect_count("preamble_749_dvi", cnt_pre[1], 0);
    expect_count("guard_after_719", cnt_g[0], 0);
  endtask

  // line 0 with black pixels; the guard band of line 749 lands here
  task automatic test_black_line();
    clear_counts();
    bal = 0;
    run_cycles(1650, 1'b1);
    expect_count("guard_749_hdmi", cnt_g[0], 2);
    expect_count("guard_749_dvi", cnt_g[1], 0);
    expect_count("preamble_line0_dvi", cnt_pre[1], 0);
  endtask

  task automatic test_random_line();
    run_cycles(1650, 1'b0);
  endtask

  task automatic test_mid_reset();
    run_cycles(700, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      n_chk++;
      if (cx[i] !== 11'(sx_a[i]) || cy[i] !== 10'(sy_a[i]) || tm[i] !== {C00, C00, C00}) begin
        n_fail++;
        $display("FAIL mid_reset inst%0d: got cx=%0d cy=%0d tmds=%h", i, cx[i], cy[i], tm[i]);
      end
    end
    reset = 1'b0;
    model_reset();
    run_cycles(1700, 1'b0);
  endtask

  initial begin
    test_reset();
    test_active_lines();
    test_sync_blanking();
    test_black_line();
    test_random_line();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
